fp_divider_seq: RTL and testbench
=================================

Name: fp_divider_seq

Overview:
Parametrised, handshaked successor to the single-precision sequential divider. Computes IEEE-754-style A/B for any EXP_W/MAN_W format using a restoring radix-2 iteration, one quotient bit per cycle. Adds round-to-nearest-even, special-operand handling, exception flags and valid/ready flow control. Sits in the FPU datapath beside the adder and multiplier and is fed by the issue logic.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W
BIAS, 2**(EXP_W-1)-1, exponent bias

Ports:
fp_clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  divider can accept operands
a  in  W  dividend
b  in  W  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  W  quotient
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}, valid with out_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, result=0, flags=0, internal registers cleared. Reset mid-operation aborts the division with no output.
- States: IDLE -> DIV -> ROUND -> DONE -> IDLE. in_ready=1 only in IDLE.
- Accept: handshake when in_valid && in_ready at edge k. Operands, sign (sa^sb) and class are latched there.
- Special operands: exponent all-ones is Inf/NaN; exponent zero is zero, with subnormals flushed to zero. These go IDLE->DONE with out_valid high after edge k+1:
  - NaN operand, 0/0 or Inf/Inf: canonical qNaN (sign 0, exp all-ones, fraction MSB only set), invalid=1.
  - finite nonzero/0: signed Inf, div_by_zero=1.
  - Inf/finite: signed Inf.
  - finite/Inf or 0/nonzero: signed zero.
  - No other flags are set in these cases.
- DIV: operate on mantissas ma={1,fa} and mb={1,fb}, so the ratio is in (0.5,2). Remainder starts at ma. Each cycle: if rem>=mb, set q bit and subtract mb; then shift rem left. Produce MAN_W+3 bits, weights 2^0 .. 2^-(MAN_W+2). DIV lasts exactly MAN_W+3 cycles, counted by a down-counter.
- ROUND (one cycle):
  - If q MSB=1: frac=q[MAN_W+1:2], guard=q[1], sticky=q[0] | (rem!=0), adj=0.
  - Else: frac=q[MAN_W:1], guard=q[0], sticky=(rem!=0), adj=1.
  - RNE: increment when guard && (sticky || lsb). A mantissa carry-out renormalises and adds 1 to the exponent.
  - inexact = guard | sticky.
- Exponent: computed signed in EXP_W+2 bits as ea - eb + BIAS - adj + carry.
  - e >= 2**EXP_W-1: signed Inf, overflow=1, inexact=1.
  - e <= 0: signed zero, underflow=1, inexact=1 (flush-to-zero).
- Normal-path latency: out_valid rises after edge k+MAN_W+4 (27 cycles for the default format).
- DONE: result and flags are held stable while out_valid=1 && out_ready=0. The handshake edge clears out_valid and returns to IDLE; in_ready=1 in the following cycle (no same-cycle accept in DONE).
- in_valid while busy is ignored and the operands are not captured.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), out_ready=1 -> result=0x40400000, flags=0, out_valid exactly 27 cycles after accept.
- a=0x3F800000, b=0x40400000 (1/3) -> result=0x3EAAAAAB, flags=00001 (inexact); a=0xBF800000 -> 0xBEAAAAAB.
- a=0x3F800000, b=0x00000000 -> 0x7F800000, div_by_zero=1, after 2 cycles; a=0, b=0 -> 0x7FC00000, invalid=1; a=0x7FC00001, b=1.0 -> 0x7FC00000, invalid=1.
- a=0x7F000000, b=0x3E800000 -> 0x7F800000, overflow+inexact. a=0x00800000, b=0x7F000000 -> 0x00000000, underflow+inexact.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle. Back-to-back issues then produce correct results in order.
- Drop rst_n for 1 cycle at DIV cycle 10 -> out_valid stays 0 and in_ready=1 immediately. A new 6.0/2.0 then yields 0x40400000.

Source files
------------

// File: rtl/fp_div_if.sv
// Operand/result handshake bundle between the FPU issue logic and the divider.
// The master drives operands and consumes results; the slave is the divider.
interface fp_div_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [4:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_divider_seq.sv
// Sequential restoring radix-2 floating-point divider, one quotient bit per cycle,
// with round-to-nearest-even, flush-to-zero and exception flags.
module fp_divider_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BIAS  = 2**(EXP_W-1)-1
) (
   input  logic     fp_clk,
   input  logic     rst_n,
   fp_div_if.slave  bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int QW = MAN_W + 3;
   localparam int CW = $clog2(QW) + 1;
   localparam logic [CW-1:0]        CNT_INIT = CW'(QW - 1);
   localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
   localparam logic signed [EXP_W+1:0] EMAX_S = {2'b00, {EXP_W{1'b1}}};
   localparam logic signed [EXP_W+1:0] ZERO_S = '0;
   localparam logic [W-2:0] INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
   localparam logic [W-1:0] QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

   state_t            state_q, state_d;
   logic [EXP_W-1:0]  ea_q, eb_q;
   logic [MAN_W-1:0]  fa_q, fb_q;
   logic              sign_q;
   logic              special_q;
   logic [MAN_W+1:0]  rem_q;
   logic [QW-1:0]     q_q;
   logic [CW-1:0]     cnt_q;
   logic [W-1:0]      result_q;
   logic [4:0]        flags_q;

   function automatic logic is_special(input logic [EXP_W-1:0] e);
      return (&e) | ~(|e);
   endfunction

   // RNE increment; the extra MSB is the mantissa carry-out.
   function automatic logic [MAN_W:0] rne_round(input logic [MAN_W-1:0] frac,
                                               input logic guard, input logic sticky);
      logic inc;
      inc = guard & (sticky | frac[0]);
      return {1'b0, frac} + {{MAN_W{1'b0}}, inc};
   endfunction

   function automatic logic signed [EXP_W+1:0] exp_calc(input logic [EXP_W-1:0] ea,
                                                        input logic [EXP_W-1:0] eb,
                                                        input logic adj, input logic carry);
      return $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S
             - $signed({{(EXP_W+1){1'b0}}, adj}) + $signed({{(EXP_W+1){1'b0}}, carry});
   endfunction

   // Saturate to Inf on overflow, flush to zero on underflow; returns {flags, result}.
   function automatic logic [W+4:0] pack_normal(input logic s,
                                                input logic signed [EXP_W+1:0] e,
                                                input logic [MAN_W-1:0] frac,
                                                input logic inexact);
      if (e >= EMAX_S)
         return {5'b00101, s, INF_MAG};
      else if (e <= ZERO_S)
         return {5'b00011, s, {(W-1){1'b0}}};
      else
         return {4'b0000, inexact, s, e[EXP_W-1:0], frac};
   endfunction

   function automatic logic [W+4:0] pack_special(input logic s,
                                                 input logic [EXP_W-1:0] ea,
                                                 input logic [MAN_W-1:0] fa,
                                                 input logic [EXP_W-1:0] eb,
                                                 input logic [MAN_W-1:0] fb);
      logic a_inf, a_nan, a_zero, b_inf, b_nan, b_zero;
      a_inf  = (&ea) & ~(|fa);
      a_nan  = (&ea) & (|fa);
      a_zero = ~(|ea);
      b_inf  = (&eb) & ~(|fb);
      b_nan  = (&eb) & (|fb);
      b_zero = ~(|eb);
      if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
         return {5'b10000, QNAN};
      else if (a_inf)
         return {5'b00000, s, INF_MAG};
      else if (b_zero)
         return {5'b01000, s, INF_MAG};
      else
         return {5'b00000, s, {(W-1){1'b0}}};
   endfunction

   logic              in_special;
   logic [MAN_W+1:0]  mb_ext, diff, rem_nxt;
   logic              ge;
   logic              q_msb, guard, sticky, adj, carry;
   logic [MAN_W-1:0]  frac_pre, frac_rnd;
   logic [MAN_W:0]    rnd;
   logic signed [EXP_W+1:0] e_s;
   logic [W+4:0]      nm_pack, sp_pack;

   assign in_special = is_special(bus.a[W-2:MAN_W]) | is_special(bus.b[W-2:MAN_W]);

   // Restoring step: subtract when the divisor fits, then shift the remainder.
   assign mb_ext  = {2'b01, fb_q};
   assign ge      = (rem_q >= mb_ext);
   assign diff    = ge ? (rem_q - mb_ext) : rem_q;
   assign rem_nxt = diff << 1;

   assign q_msb    = q_q[QW-1];
   assign frac_pre = q_msb ? q_q[MAN_W+1:2] : q_q[MAN_W:1];
   assign guard    = q_msb ? q_q[1] : q_q[0];
   assign sticky   = (q_msb & q_q[0]) | (rem_q != '0);
   assign adj      = ~q_msb;
   assign rnd      = rne_round(frac_pre, guard, sticky);
   assign carry    = rnd[MAN_W];
   assign frac_rnd = rnd[MAN_W-1:0];
   assign e_s      = exp_calc(ea_q, eb_q, adj, carry);
   assign nm_pack  = pack_normal(sign_q, e_s, frac_rnd, guard | sticky);
   assign sp_pack  = pack_special(sign_q, ea_q, fa_q, eb_q, fb_q);

   always_ff @(posedge fp_clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Special operands skip DIV and resolve in the single ROUND cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = in_special ? ROUND : DIV;
         DIV:     if (cnt_q == '0) state_d = ROUND;
         ROUND:   state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge fp_clk or negedge rst_n) begin
      if (!rst_n) begin
         ea_q      <= '0;
         eb_q      <= '0;
         fa_q      <= '0;
         fb_q      <= '0;
         sign_q    <= 1'b0;
         special_q <= 1'b0;
         rem_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         flags_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               ea_q      <= bus.a[W-2:MAN_W];
               fa_q      <= bus.a[MAN_W-1:0];
               eb_q      <= bus.b[W-2:MAN_W];
               fb_q      <= bus.b[MAN_W-1:0];
               sign_q    <= bus.a[W-1] ^ bus.b[W-1];
               special_q <= in_special;
               rem_q     <= {2'b01, bus.a[MAN_W-1:0]};
               q_q       <= '0;
               cnt_q     <= CNT_INIT;
            end
            DIV: begin
               rem_q <= rem_nxt;
               q_q   <= {q_q[QW-2:0], ge};
               if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end
            ROUND: {flags_q, result_q} <= special_q ? sp_pack : nm_pack;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_divider_seq.sv
// Bench for fp_divider_seq: vector table with latency checks, scoreboard-driven
// result checking, plus backpressure, back-to-back and mid-operation reset sequences.
module tb_fp_divider_seq;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   fp_div_if #(.W(32)) bus ();

   fp_divider_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .fp_clk (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
   } vec_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Result checker: the consumer takes a result on the coming edge.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h, required no output", bus.result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("flags", {27'd0, bus.flags}, {27'd0, e.flg});
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [4:0] flg, input bit expect_out);
      int t;
      exp_t e;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0, required 1");
      end
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      @(posedge clk);
      if (expect_out) begin
         e.res = res;
         e.flg = flg;
         sb.push_back(e);
      end
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      end
   endtask

   vec_t vecs[$];

   initial begin
      int n;
      bit saw_valid;

      vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27});
      vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27});
      vecs.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'b00001, 27});
      vecs.push_back('{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 27});
      vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 27});
      vecs.push_back('{32'h40C00000, 32'hC0000000, 32'hC0400000, 5'b00000, 27});
      vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 27});
      vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 5'b00011, 27});
      vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1});
      vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1});
      vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1});
      vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1});
      vecs.push_back('{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 1});
      vecs.push_back('{32'h40000000, 32'h7F800000, 32'h00000000, 5'b00000, 1});
      vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 1});
      vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1});

      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      #1;
      chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      chk("reset_flags", {27'd0, bus.flags}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, 1'b1);
         n = 0;
         while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk($sformatf("latency_%0d", i), n, vecs[i].lat);
         @(posedge clk);
         #1;
      end
      drain();

      // Backpressure, with ignored operands offered while busy.
      bus.out_ready = 1'b0;
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b1);
      bus.in_valid = 1'b1;
      bus.a = 32'h3F800000;
      bus.b = 32'h40400000;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_latency", n, 27);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("bp_result_hold", bus.result, 32'h40400000);
         chk("bp_state_hold", {27'd0, bus.flags, bus.in_ready, bus.out_valid}, 32'b01);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
      drain();

      // Back-to-back issue, results must come out in order.
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 1'b1);
      issue(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1'b1);
      issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 1'b1);
      issue(32'h40400000, 32'h3F800000, 32'h40400000, 5'b00000, 1'b1);
      drain();

      // Reset during DIV aborts with no output.
      issue(32'h40C00000, 32'h40000000, 32'h0, 5'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) saw_valid = 1'b1;
      end
      chk("abort_no_output", {31'd0, saw_valid}, 32'd0);
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
